// File: rtl/pe_pkt_pkg.sv
// rtl/pe_pkt_pkg.sv - shared PE packet field layout, FSM states and packing helpers
package pe_pkt_pkg;

  localparam int TS_BIT        = 0;
  localparam int MODE_BIT      = 1;
  localparam int ROW_LSB       = 2;
  localparam int DATA_LSB      = 4;
  localparam int ROW_W         = 2;
  localparam int ELEMS_PER_PKT = 3;
  localparam int LAST_ROW      = 2;

  localparam logic MODE_IFMAP  = 1'b0;
  localparam logic MODE_FILTER = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } pkt_state_e;

  function automatic int pkt_width(input int filter_width);
    return ELEMS_PER_PKT * filter_width + DATA_LSB;
  endfunction

  // Header nibble below the element payload; shared with the depacketizer.
  function automatic logic [DATA_LSB-1:0] pkt_header(input logic mode,
                                                     input logic ts,
                                                     input logic [ROW_W-1:0] row);
    logic [DATA_LSB-1:0] h;
    h                   = '0;
    h[TS_BIT]           = ts;
    h[MODE_BIT]         = mode;
    h[ROW_LSB +: ROW_W] = row;
    return h;
  endfunction

endpackage

// File: rtl/pe_packetizer_if.sv
// rtl/pe_packetizer_if.sv - command, element and packet handshake bundle of the PE packetizer
interface pe_packetizer_if
  import pe_pkt_pkg::*;
#(
  parameter int FILTER_WIDTH = 8
);

  localparam int PKT_W = pkt_width(FILTER_WIDTH);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_mode;
  logic                    cmd_timestep;
  logic                    elem_valid;
  logic                    elem_ready;
  logic [FILTER_WIDTH-1:0] elem_data;
  logic                    pkt_valid;
  logic                    pkt_ready;
  logic [PKT_W-1:0]        pkt_data;
  logic                    busy;

  // master: data source / NoC side; slave: the packetizer itself.
  modport master (
    output cmd_valid, cmd_mode, cmd_timestep, elem_valid, elem_data, pkt_ready,
    input  cmd_ready, elem_ready, pkt_valid, pkt_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_timestep, elem_valid, elem_data, pkt_ready,
    output cmd_ready, elem_ready, pkt_valid, pkt_data, busy
  );

endinterface

// File: rtl/pe_packetizer.sv
// rtl/pe_packetizer.sv - builds three 3-element row packets per command for NoC injection
module pe_packetizer
  import pe_pkt_pkg::*;
#(
  parameter int FILTER_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  pe_packetizer_if.slave  bus
);

  localparam int PKT_W  = pkt_width(FILTER_WIDTH);
  localparam int DATA_W = PKT_W - DATA_LSB;

  pkt_state_e        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              ts_q, ts_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_IFMAP;
      ts_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ts_q    <= ts_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ts_d    = ts_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          mode_d  = (bus.cmd_mode == MODE_FILTER);
          ts_d    = bus.cmd_timestep;
          row_d   = '0;
          cnt_d   = '0;
          data_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.elem_valid) begin
          for (int k = 0; k < ELEMS_PER_PKT; k++) begin
            if (cnt_q == 2'(k)) begin
              data_d[k*FILTER_WIDTH +: FILTER_WIDTH] = bus.elem_data;
            end
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(ELEMS_PER_PKT - 1)) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (bus.pkt_ready) begin
          // Row saturates at the last row: the final handshake ends the command.
          if (row_q == ROW_W'(LAST_ROW)) begin
            data_d  = '0;
            state_d = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            cnt_d   = '0;
            state_d = COLLECT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All handshake outputs are pure decodes of the registered state.
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.elem_ready = (state_q == COLLECT);
  assign bus.pkt_valid  = (state_q == SEND);
  assign bus.busy       = (state_q != IDLE);
  assign bus.pkt_data   = (state_q == SEND) ? {data_q, pkt_header(mode_q, ts_q, row_q)}
                                            : '0;

endmodule

// File: tb/tb_pe_packetizer.sv
// tb/tb_pe_packetizer.sv - randomized self-checking bench for pe_packetizer
module tb_pe_packetizer;
  import pe_pkt_pkg::*;

  localparam int FW    = 8;
  localparam int PKT_W = 3 * FW + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_packetizer_if #(.FILTER_WIDTH(FW)) bus ();

  pe_packetizer #(.FILTER_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [PKT_W-1:0] got_q[$];
  logic [PKT_W-1:0] stall_q[$];
  int               stall_viol;
  int               busy_viol;

  always @(negedge clk) begin
    if (!rst && bus.pkt_valid && bus.pkt_ready) got_q.push_back(bus.pkt_data);
  end

  function automatic logic [PKT_W-1:0] model_pkt(input bit mode, input bit ts,
                                                  input logic [7:0] e [9], input int r);
    logic [PKT_W-1:0] p;
    p = PKT_W'(ts) + PKT_W'(mode) * 2 + PKT_W'(r) * 4;
    for (int k = 0; k < 3; k++) p = p + (PKT_W'(e[3*r+k]) << (4 + 8*k));
    return p;
  endfunction

  task automatic rand_elems(output logic [7:0] e [9]);
    for (int i = 0; i < 9; i++) e[i] = 8'($urandom);
  endtask

  // Drives one command and its nine elements; records observations only.
  task automatic drive_cmd(input bit mode, input bit ts, input logic [7:0] e [9],
                           input bit skip_cmd, input bit gaps,
                           input int stall_row, input int stall_len,
                           input bit hold_next, input bit hold_mode, input bit hold_ts,
                           output int cycles, output bit timeout, output bit next_taken);
    int  idx, npkt, stall_left;
    bit  stall_done, cmd_seen, cmd_acc, elem_acc, pkt_acc;
    idx = 0; npkt = 0; stall_left = 0; stall_done = 0;
    cycles = 0; timeout = 0; next_taken = 0;
    cmd_seen = skip_cmd;
    stall_q.delete(); stall_viol = 0; busy_viol = 0;
    bus.cmd_valid    = !skip_cmd;
    bus.cmd_mode     = mode;
    bus.cmd_timestep = ts;
    bus.elem_valid   = 1'b1;
    bus.elem_data    = e[0];
    bus.pkt_ready    = 1'b1;
    while (npkt < 3) begin
      @(negedge clk);
      cycles++;
      if (cycles > 300) begin timeout = 1; break; end
      if (stall_left > 0) begin
        stall_q.push_back(bus.pkt_data);
        if (bus.elem_ready || bus.cmd_ready || !bus.pkt_valid) stall_viol++;
      end
      if (cmd_seen && (bus.cmd_ready || !bus.busy)) busy_viol++;
      cmd_acc  = bus.cmd_valid && bus.cmd_ready;
      elem_acc = bus.elem_valid && bus.elem_ready;
      pkt_acc  = bus.pkt_valid && bus.pkt_ready;
      @(posedge clk); #1;
      if (cmd_acc) begin
        cmd_seen = 1;
        if (hold_next) begin
          bus.cmd_mode     = hold_mode;
          bus.cmd_timestep = hold_ts;
        end else begin
          bus.cmd_valid    = 1'b0;
          bus.cmd_mode     = 1'($urandom);
          bus.cmd_timestep = 1'($urandom);
        end
      end
      if (elem_acc) idx++;
      if (pkt_acc) npkt++;
      if (idx < 9) begin
        bus.elem_valid = gaps ? (cycles % 2 == 0) : 1'b1;
        bus.elem_data  = bus.elem_valid ? e[idx] : 8'($urandom);
      end else begin
        bus.elem_valid = 1'b0;
        bus.elem_data  = 8'($urandom);
      end
      if (stall_left > 0) stall_left--;
      if (!stall_done && npkt == stall_row && bus.pkt_valid) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      bus.pkt_ready = (stall_left == 0);
    end
    bus.elem_valid = 1'b0;
    bus.pkt_ready  = 1'b1;
    if (hold_next && !timeout) begin
      @(negedge clk);
      next_taken = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    compared++; if (bus.elem_ready !== 1'b0) begin mismatched++; $display("FAIL reset_elem_ready: got %b want 0", bus.elem_ready); end
    compared++; if (bus.pkt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_pkt_valid: got %b want 0", bus.pkt_valid); end
    compared++; if (bus.pkt_data !== '0) begin mismatched++; $display("FAIL reset_pkt_data: got %h want 0", bus.pkt_data); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_filter();
    logic [7:0]       e [9];
    logic [PKT_W-1:0] fixed [3];
    int cyc; bit to, nt;
    for (int i = 0; i < 9; i++) e[i] = 8'(i + 1);
    fixed[0] = 28'h0302013; fixed[1] = 28'h0605047; fixed[2] = 28'h090807B;
    got_q.delete();
    drive_cmd(MODE_FILTER, 1'b1, e, 0, 0, -1, 0, 0, 0, 0, cyc, to, nt);
    compared++; if (to) begin mismatched++; $display("FAIL filter_timeout: got timeout want done"); end
    compared++; if (cyc != 13) begin mismatched++; $display("FAIL filter_cycles: got %0d want 13", cyc); end
    compared++; if (got_q.size() != 3) begin mismatched++; $display("FAIL filter_count: got %0d want 3", got_q.size()); end
    for (int r = 0; r < 3 && r < got_q.size(); r++) begin
      compared++;
      if (got_q[r] !== fixed[r] || got_q[r] !== model_pkt(1'b1, 1'b1, e, r)) begin
        mismatched++; $display("FAIL filter_pkt%0d: got %h want %h", r, got_q[r], fixed[r]);
      end
    end
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pkt_data !== '0) begin
      mismatched++; $display("FAIL filter_idle: got rdy=%b busy=%b data=%h want 1 0 0", bus.cmd_ready, bus.busy, bus.pkt_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ifmap();
    logic [7:0]       e [9];
    logic [PKT_W-1:0] fixed [3];
    int cyc; bit to, nt;
    for (int i = 0; i < 9; i++) e[i] = 8'(8'hA0 + i);
    fixed[0] = 28'hA2A1A00; fixed[1] = 28'hA5A4A34; fixed[2] = 28'hA8A7A68;
    got_q.delete();
    drive_cmd(MODE_IFMAP, 1'b0, e, 0, 0, -1, 0, 0, 0, 0, cyc, to, nt);
    compared++; if (got_q.size() != 3 || to) begin mismatched++; $display("FAIL ifmap_count: got %0d want 3", got_q.size()); end
    for (int r = 0; r < 3 && r < got_q.size(); r++) begin
      compared++;
      if (got_q[r] !== fixed[r]) begin mismatched++; $display("FAIL ifmap_pkt%0d: got %h want %h", r, got_q[r], fixed[r]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [9];
    bit mode, ts, to, nt; int cyc;
    logic [PKT_W-1:0] exp_row1;
    rand_elems(e);
    mode = 1'($urandom); ts = 1'($urandom);
    exp_row1 = model_pkt(mode, ts, e, 1);
    got_q.delete();
    drive_cmd(mode, ts, e, 0, 0, 1, 5, 0, 0, 0, cyc, to, nt);
    compared++; if (stall_q.size() != 5) begin mismatched++; $display("FAIL bp_stall_len: got %0d want 5", stall_q.size()); end
    for (int i = 0; i < stall_q.size(); i++) begin
      compared++;
      if (stall_q[i] !== exp_row1) begin mismatched++; $display("FAIL bp_hold%0d: got %h want %h", i, stall_q[i], exp_row1); end
    end
    compared++; if (stall_viol != 0) begin mismatched++; $display("FAIL bp_ready_during_stall: got %0d bad cycles want 0", stall_viol); end
    compared++; if (cyc != 18 || to) begin mismatched++; $display("FAIL bp_cycles: got %0d want 18", cyc); end
    compared++; if (got_q.size() != 3) begin mismatched++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int r = 0; r < 3 && r < got_q.size(); r++) begin
      compared++;
      if (got_q[r] !== model_pkt(mode, ts, e, r)) begin mismatched++; $display("FAIL bp_pkt%0d: got %h want %h", r, got_q[r], model_pkt(mode, ts, e, r)); end
    end
  endtask

  task automatic test_gaps_hold();
    logic [7:0] e1 [9];
    logic [7:0] e2 [9];
    bit m1, t1, m2, t2, to, nt, nt2; int cyc;
    rand_elems(e1); rand_elems(e2);
    m1 = 1'($urandom); t1 = 1'($urandom); m2 = ~m1; t2 = 1'($urandom);
    got_q.delete();
    drive_cmd(m1, t1, e1, 0, 1, -1, 0, 1, m2, t2, cyc, to, nt);
    compared++; if (busy_viol != 0) begin mismatched++; $display("FAIL hold_busy: got %0d bad cycles want 0", busy_viol); end
    compared++; if (nt !== 1'b1) begin mismatched++; $display("FAIL hold_next_accept: got %b want 1", nt); end
    compared++; if (got_q.size() != 3 || to) begin mismatched++; $display("FAIL gaps_count: got %0d want 3", got_q.size()); end
    for (int r = 0; r < 3 && r < got_q.size(); r++) begin
      compared++;
      if (got_q[r] !== model_pkt(m1, t1, e1, r)) begin mismatched++; $display("FAIL gaps_pkt%0d: got %h want %h", r, got_q[r], model_pkt(m1, t1, e1, r)); end
    end
    got_q.delete();
    drive_cmd(m2, t2, e2, 1, 0, -1, 0, 0, 0, 0, cyc, to, nt2);
    compared++; if (got_q.size() != 3 || to) begin mismatched++; $display("FAIL second_count: got %0d want 3", got_q.size()); end
    for (int r = 0; r < 3 && r < got_q.size(); r++) begin
      compared++;
      if (got_q[r] !== model_pkt(m2, t2, e2, r)) begin mismatched++; $display("FAIL second_pkt%0d: got %h want %h", r, got_q[r], model_pkt(m2, t2, e2, r)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e [9];
    bit mode, ts, acc, cacc, to, nt; int n, cyc;
    rand_elems(e);
    got_q.delete();
    bus.cmd_valid = 1'b1; bus.cmd_mode = 1'($urandom); bus.cmd_timestep = 1'($urandom);
    bus.elem_valid = 1'b1; bus.elem_data = e[0]; bus.pkt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      acc  = bus.elem_valid && bus.elem_ready;
      cacc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (cacc) bus.cmd_valid = 1'b0;
      if (acc) begin n++; bus.elem_data = e[n]; end
    end
    compared++; if (n != 5) begin mismatched++; $display("FAIL rmid_progress: got %0d elems want 5", n); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.elem_valid = 1'b0;
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b1 || bus.elem_ready !== 1'b0 || bus.pkt_valid !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL rmid_outputs: got cr=%b er=%b pv=%b busy=%b want 1 0 0 0", bus.cmd_ready, bus.elem_ready, bus.pkt_valid, bus.busy);
    end
    compared++; if (bus.pkt_data !== '0) begin mismatched++; $display("FAIL rmid_pkt_data: got %h want 0", bus.pkt_data); end
    compared++; if (got_q.size() != 1) begin mismatched++; $display("FAIL rmid_emitted: got %0d want 1", got_q.size()); end
    @(posedge clk); #1;
    rand_elems(e);
    mode = 1'($urandom); ts = 1'($urandom);
    got_q.delete();
    drive_cmd(mode, ts, e, 0, 0, -1, 0, 0, 0, 0, cyc, to, nt);
    compared++; if (got_q.size() != 3 || to) begin mismatched++; $display("FAIL rmid_fresh_count: got %0d want 3", got_q.size()); end
    compared++; if (got_q.size() > 0 && got_q[0] !== model_pkt(mode, ts, e, 0)) begin
      mismatched++; $display("FAIL rmid_fresh_row0: got %h want %h", got_q[0], model_pkt(mode, ts, e, 0));
    end
  endtask

  task automatic test_random();
    logic [7:0] e [9];
    bit mode, ts, gaps, to, nt; int cyc, srow;
    for (int t = 0; t < 6; t++) begin
      rand_elems(e);
      mode = 1'($urandom); ts = 1'($urandom); gaps = 1'($urandom);
      srow = int'($urandom_range(0, 3)) - 1;
      got_q.delete();
      drive_cmd(mode, ts, e, 0, gaps, srow, int'($urandom_range(1, 4)), 0, 0, 0, cyc, to, nt);
      compared++; if (got_q.size() != 3 || to) begin mismatched++; $display("FAIL rand%0d_count: got %0d want 3", t, got_q.size()); end
      for (int r = 0; r < 3 && r < got_q.size(); r++) begin
        compared++;
        if (got_q[r] !== model_pkt(mode, ts, e, r)) begin mismatched++; $display("FAIL rand%0d_pkt%0d: got %h want %h", t, r, got_q[r], model_pkt(mode, ts, e, r)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_timestep = 1'b0;
    bus.elem_valid = 1'b0; bus.elem_data = '0; bus.pkt_ready = 1'b0;
    test_reset();
    test_filter();
    test_ifmap();
    test_backpressure();
    test_gaps_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pe_packetizer.md
# pe_packetizer

Clocked packet builder for the PE network interface. It takes a short command (ifmap/filter select plus timestep) and a stream of data elements, and emits the packets the PE-side depacketizer consumes. Each command produces three packets, one per row 0..2, and each packet carries three elements. The block sits between the data source (weight/ifmap loader) and the NoC injection port.

## Interface
Parameters:
- FILTER_WIDTH, 8, width of one data element in bits; packet width is PKT_W = 3*FILTER_WIDTH+4

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_mode  in  1  0 = ifmap, 1 = filter (packet bit [1])
- cmd_timestep  in  1  timestep bit (packet bit [0])
- elem_valid  in  1  data element offered
- elem_ready  out  1  element accepted when elem_valid & elem_ready
- elem_data  in  FILTER_WIDTH  element value
- pkt_valid  out  1  packet available
- pkt_ready  in  1  downstream takes the packet when pkt_valid & pkt_ready
- pkt_data  out  PKT_W  packet
- busy  out  1  high from command accept until the row-2 packet is taken

## Operation
- Packet layout: [0] timestep, [1] ifmap(0)/filter(1), [3:2] row, [4+k*FILTER_WIDTH +: FILTER_WIDTH] element k, k = 0..2. Element k is the k-th element accepted for that row.
- FSM states:
  - IDLE: cmd_ready=1. Accepting a command latches mode/timestep, clears row=0 and elem_cnt=0, and moves to COLLECT.
  - COLLECT: elem_ready=1. Each accept writes element elem_cnt and increments elem_cnt. The accept at elem_cnt==2 moves to SEND.
  - SEND: pkt_valid=1 and pkt_data is held stable until handshake. On handshake: if row==2, go to IDLE; else row+1, elem_cnt=0, go to COLLECT.
- Rules:
  - Row counter never exceeds 2; no wrap to 3.
  - cmd_ready=0 outside IDLE; a cmd_valid held high waits there.
  - elem_ready=0 outside COLLECT; no elements are accepted while a packet waits.
  - In ifmap mode, bit [1]=0; the consumer additionally uses bit [0]. In filter mode the timestep bit is still driven with the latched value.
  - Command fields are sampled only on command accept; later changes on cmd_* are ignored.
  - rst in any state: go to IDLE, clear counters and the data register, and abandon any partial packet (not emitted).

## Timing
- Reset values:
  - cmd_ready=1 (IDLE), elem_ready=0, pkt_valid=0, pkt_data=0, busy=0.
  - pkt_data stays 0 in IDLE; it is not required to be meaningful except when pkt_valid=1.
- Latency:
  - The third element accepted at edge N gives pkt_valid=1 after edge N (visible in cycle N+1).
  - With pkt_ready tied high and elements every cycle, one command takes 1 + 3*(3+1) = 13 cycles.
- Handshakes:
  - Every output valid/ready signal is a registered state decode; ready never depends combinationally on valid.
  - pkt_valid, once high, stays high with pkt_data unchanged until pkt_ready.
- Back-to-back commands:
  - The handshake on the row-2 packet returns the block to IDLE.
  - The next command can be accepted in the following cycle; there is no same-cycle overlap.
- Simultaneous rst with any handshake: rst wins, and the handshake is void.

## Structure
- Shared package pe_pkt_pkg holds:
  - bit offsets TS_BIT=0, MODE_BIT=1, ROW_LSB=2, DATA_LSB=4
  - MODE_IFMAP/MODE_FILTER constants
  - the state enum {IDLE, COLLECT, SEND}
  - function pkt_width(FILTER_WIDTH)
- The package is shared with the depacketizer and any packet monitor.
- A single module; no sub-module is needed. Field packing is done with a package function.

## Test plan
Cases use FILTER_WIDTH=8, PKT_W=28.
- Reset: hold rst 2 cycles, then check cmd_ready=1, elem_ready=0, pkt_valid=0, pkt_data=0, busy=0.
- Filter command: cmd mode=1 ts=1, elements 0x01..0x09 streamed, pkt_ready=1 -> packets 28'h0302013, 28'h0605047, 28'h090807B in order, then IDLE; 13 cycles total.
- Ifmap command: cmd mode=0 ts=0, elements 0xA0..0xA8 -> 28'hA2A1A00, 28'hA5A4A34, 28'hA8A7A68.
- Backpressure: pkt_ready=0 for 5 cycles on row 1 -> pkt_data stable at row-1 value, elem_ready=0, cmd_ready=0 throughout; resumes correctly afterwards.
- Gaps and command hold: elem_valid toggled every other cycle, plus a second cmd_valid held during busy -> correct packets; second command accepted exactly one cycle after the row-2 handshake.
- Mid-operation reset: rst asserted after 2 elements of row 1 -> next cycle IDLE with all outputs at reset values; a fresh command produces a clean row-0 packet.
